// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding and active-low seven-segment patterns
package bcd_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-low segments with blank and dash overrides
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);
    assign o_seg = i_dash ? SEG_DASH : (i_blank || i_bcd > 4'd9) ? SEG_BLANK : SEG_TABLE[i_bcd];
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: double-dabble binary to BCD conversion driving seven-segment displays
module bcd_display_driver
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      VALUE,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  OVERFLOW
);
    localparam int ACC_D = (WIDTH + 2) / 3 + 1;
    localparam int ACC_W = 4 * ACC_D;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t r_state, w_next;
    logic [WIDTH-1:0] r_val;
    logic [ACC_W-1:0] r_acc, w_adj;
    logic [CW-1:0] r_cnt;
    logic r_done, r_ovf;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS+ACC_W-1:0] w_wide;
    logic [DIGITS-1:0] w_blank;
    logic w_accept, w_last;

    assign w_accept = START && r_state != ST_SHIFT;
    assign w_last = r_state == ST_SHIFT && r_cnt == CNT_LAST;
    assign w_wide = {{(4*DIGITS){1'b0}}, r_acc};

    for (genvar g = 0; g < ACC_D; g++) begin : g_adj
        assign w_adj[4*g +: 4] = r_acc[4*g +: 4] >= 4'd5 ? r_acc[4*g +: 4] + 4'd3 : r_acc[4*g +: 4];
    end

    // state register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // next state: accept from any non-shifting state, leave SHIFT after the final shift count
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? ST_SHIFT : w_last ? ST_FINISH : r_state == ST_FINISH ? ST_IDLE : r_state;
    end

    // datapath: capture on accept, shift while counting, publish results on FINISH entry
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_val <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_done <= 1'b0;
            r_ovf <= 1'b0;
            r_bcd <= '0;
        end else begin
            if (w_accept) begin
                r_val <= VALUE;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT && !w_last) begin
                r_acc <= ACC_W'({w_adj, r_val[WIDTH-1]});
                r_val <= {r_val[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt + CW'(1);
            end
            r_done <= w_last;
            if (w_last) begin
                r_bcd <= w_wide[4*DIGITS-1:0];
                r_ovf <= |w_wide[4*DIGITS+ACC_W-1:4*DIGITS];
            end
        end
    end

    // a digit is blank when it and every digit above it are zero; the ones digit always shows
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        assign w_blank[g] = BLANK_LZ != 0 && g != 0 && (r_bcd >> (4*g)) == '0;
        seg7_decode u_dec (
            .i_bcd   (r_bcd[4*g +: 4]),
            .i_blank (w_blank[g]),
            .i_dash  (r_ovf),
            .o_seg   (HEX[7*g +: 7])
        );
    end

    assign BUSY = r_state == ST_SHIFT;
    assign DONE = r_done;
    assign BCD = r_bcd;
    assign OVERFLOW = r_ovf;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed checks of conversion, blanking, overflow, restart and reset
module tb_bcd_display_driver;
    logic clk, rst_n;
    logic s_a, s_b, s_c, s_d;
    logic [7:0] v_a, v_b, v_c;
    logic [15:0] v_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic ovf_a, ovf_b, ovf_c, ovf_d;
    logic [11:0] bcd_a, bcd_b;
    logic [7:0] bcd_c;
    logic [19:0] bcd_d;
    logic [20:0] hex_a, hex_b;
    logic [13:0] hex_c;
    logic [34:0] hex_d;
    int tot, bad;

    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .VALUE(v_a), .START(s_a), .BUSY(busy_a),
        .DONE(done_a), .BCD(bcd_a), .HEX(hex_a), .OVERFLOW(ovf_a));
    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .VALUE(v_b), .START(s_b), .BUSY(busy_b),
        .DONE(done_b), .BCD(bcd_b), .HEX(hex_b), .OVERFLOW(ovf_b));
    bcd_display_driver #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) u_c (
        .CLOCK_50(clk), .RESET_N(rst_n), .VALUE(v_c), .START(s_c), .BUSY(busy_c),
        .DONE(done_c), .BCD(bcd_c), .HEX(hex_c), .OVERFLOW(ovf_c));
    bcd_display_driver #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) u_d (
        .CLOCK_50(clk), .RESET_N(rst_n), .VALUE(v_d), .START(s_d), .BUSY(busy_d),
        .DONE(done_d), .BCD(bcd_d), .HEX(hex_d), .OVERFLOW(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [23:0] m_bcd(input int v, input int nd);
        int x;
        logic [23:0] r;
        x = v;
        r = '0;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] m_hex(input int v, input int nd, input bit blz);
        int x;
        logic [41:0] h;
        x = v;
        h = '0;
        for (int k = 0; k < nd; k++) begin
            if (v >= 10 ** nd) h[7*k +: 7] = 7'h3F;
            else if (blz && k > 0 && v < 10 ** k) h[7*k +: 7] = 7'h7F;
            else h[7*k +: 7] = seg(4'(x % 10));
            x = x / 10;
        end
        return h;
    endfunction

    function automatic logic done_of(input int w);
        return w == 0 ? done_a : w == 1 ? done_b : w == 2 ? done_c : done_d;
    endfunction

    task automatic go(input int w, input int v);
        @(negedge clk);
        if (w == 0) begin v_a = v[7:0]; s_a = 1'b1; end
        else if (w == 1) begin v_b = v[7:0]; s_b = 1'b1; end
        else if (w == 2) begin v_c = v[7:0]; s_c = 1'b1; end
        else begin v_d = v[15:0]; s_d = 1'b1; end
        @(negedge clk);
        s_a = 1'b0; s_b = 1'b0; s_c = 1'b0; s_d = 1'b0;
    endtask

    task automatic wait_done(input int w, output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_of(w)) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tot++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy_a); end
        tot++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%h want=0", done_a); end
        tot++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%h want=0", ovf_a); end
        tot++; if (bcd_a !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h want=000", bcd_a); end
        tot++; if (hex_a !== {7'h7F, 7'h7F, 7'h40}) begin bad++; $display("FAIL reset_hex_a got=%h want=%h", hex_a, {7'h7F, 7'h7F, 7'h40}); end
        tot++; if (hex_b !== {7'h40, 7'h40, 7'h40}) begin bad++; $display("FAIL reset_hex_b got=%h want=%h", hex_b, {7'h40, 7'h40, 7'h40}); end
        tot++; if (hex_c !== {7'h7F, 7'h40}) begin bad++; $display("FAIL reset_hex_c got=%h want=%h", hex_c, {7'h7F, 7'h40}); end
        tot++; if (hex_d !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin bad++; $display("FAIL reset_hex_d got=%h", hex_d); end
        rst_n = 1'b1;
    endtask

    task automatic test_convert_255;
        int lat;
        go(0, 255);
        tot++; if (busy_a !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%h want=1", busy_a); end
        wait_done(0, lat);
        tot++; if (lat != 9) begin bad++; $display("FAIL latency_255 got=%0d want=9", lat); end
        tot++; if (bcd_a !== 12'h255) begin bad++; $display("FAIL bcd_255 got=%h want=255", bcd_a); end
        tot++; if (hex_a !== {7'h24, 7'h12, 7'h12}) begin bad++; $display("FAIL hex_255 got=%h want=%h", hex_a, {7'h24, 7'h12, 7'h12}); end
        tot++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_255 got=%h want=0", ovf_a); end
        tot++; if (busy_a !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%h want=0", busy_a); end
        @(negedge clk);
        tot++; if (done_a !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%h want=0", done_a); end
    endtask

    task automatic test_values;
        int va [5] = '{0, 7, 40, 100, 209};
        logic [11:0] ba [5] = '{12'h000, 12'h007, 12'h040, 12'h100, 12'h209};
        logic [20:0] ha [5] = '{{7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h19, 7'h40},
                                {7'h79, 7'h40, 7'h40}, {7'h24, 7'h40, 7'h10}};
        int vb [3] = '{0, 5, 250};
        logic [11:0] bb [3] = '{12'h000, 12'h005, 12'h250};
        logic [20:0] hb [3] = '{{7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h12}, {7'h24, 7'h12, 7'h40}};
        int lat;
        for (int i = 0; i < 5; i++) begin
            go(0, va[i]);
            wait_done(0, lat);
            tot++; if (lat != 9) begin bad++; $display("FAIL lat_a v=%0d got=%0d want=9", va[i], lat); end
            tot++; if (bcd_a !== ba[i]) begin bad++; $display("FAIL bcd_a v=%0d got=%h want=%h", va[i], bcd_a, ba[i]); end
            tot++; if (hex_a !== ha[i]) begin bad++; $display("FAIL hex_a v=%0d got=%h want=%h", va[i], hex_a, ha[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            go(1, vb[i]);
            wait_done(1, lat);
            tot++; if (bcd_b !== bb[i]) begin bad++; $display("FAIL bcd_b v=%0d got=%h want=%h", vb[i], bcd_b, bb[i]); end
            tot++; if (hex_b !== hb[i]) begin bad++; $display("FAIL hex_b v=%0d got=%h want=%h", vb[i], hex_b, hb[i]); end
        end
    endtask

    task automatic test_overflow;
        int vc [4] = '{100, 99, 255, 5};
        logic [7:0] bc [4] = '{8'h00, 8'h99, 8'h55, 8'h05};
        logic oc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [13:0] hc [4] = '{{7'h3F, 7'h3F}, {7'h10, 7'h10}, {7'h3F, 7'h3F}, {7'h7F, 7'h12}};
        int lat;
        for (int i = 0; i < 4; i++) begin
            go(2, vc[i]);
            wait_done(2, lat);
            tot++; if (ovf_c !== oc[i]) begin bad++; $display("FAIL ovf_c v=%0d got=%h want=%h", vc[i], ovf_c, oc[i]); end
            tot++; if (bcd_c !== bc[i]) begin bad++; $display("FAIL bcd_c v=%0d got=%h want=%h", vc[i], bcd_c, bc[i]); end
            tot++; if (hex_c !== hc[i]) begin bad++; $display("FAIL hex_c v=%0d got=%h want=%h", vc[i], hex_c, hc[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        v_a = 8'd200;
        s_a = 1'b1;
        @(negedge clk);
        v_a = 8'd7;
        wait_done(0, lat);
        tot++; if (lat != 9) begin bad++; $display("FAIL held_lat1 got=%0d want=9", lat); end
        tot++; if (bcd_a !== 12'h200) begin bad++; $display("FAIL held_bcd1 got=%h want=200", bcd_a); end
        tot++; if (hex_a !== {7'h24, 7'h40, 7'h40}) begin bad++; $display("FAIL held_hex1 got=%h want=%h", hex_a, {7'h24, 7'h40, 7'h40}); end
        wait_done(0, lat);
        s_a = 1'b0;
        tot++; if (lat != 10) begin bad++; $display("FAIL b2b_period got=%0d want=10", lat); end
        tot++; if (bcd_a !== 12'h007) begin bad++; $display("FAIL b2b_bcd2 got=%h want=007", bcd_a); end
        repeat (5) @(negedge clk);
        tot++; if (bcd_a !== 12'h007) begin bad++; $display("FAIL hold_bcd got=%h want=007", bcd_a); end
        tot++; if (hex_a !== {7'h7F, 7'h7F, 7'h78}) begin bad++; $display("FAIL hold_hex got=%h want=%h", hex_a, {7'h7F, 7'h7F, 7'h78}); end
        tot++; if (busy_a !== 1'b0) begin bad++; $display("FAIL hold_idle got=%h want=0", busy_a); end
    endtask

    task automatic test_reset_mid_shift;
        int lat, dc;
        go(0, 123);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%h want=0", busy_a); end
        tot++; if (bcd_a !== 12'h000) begin bad++; $display("FAIL mid_rst_bcd got=%h want=000", bcd_a); end
        tot++; if (hex_a !== {7'h7F, 7'h7F, 7'h40}) begin bad++; $display("FAIL mid_rst_hex got=%h", hex_a); end
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done_a) dc++;
        end
        tot++; if (dc != 0) begin bad++; $display("FAIL mid_rst_no_done got=%0d want=0", dc); end
        go(0, 42);
        wait_done(0, lat);
        tot++; if (lat != 9) begin bad++; $display("FAIL post_rst_lat got=%0d want=9", lat); end
        tot++; if (bcd_a !== 12'h042) begin bad++; $display("FAIL post_rst_bcd got=%h want=042", bcd_a); end
        tot++; if (hex_a !== {7'h7F, 7'h19, 7'h24}) begin bad++; $display("FAIL post_rst_hex got=%h want=%h", hex_a, {7'h7F, 7'h19, 7'h24}); end
    endtask

    task automatic test_sweep_16;
        int q [$];
        int lat;
        logic [23:0] eb;
        logic [41:0] eh;
        for (int v = 0; v < 300; v++) q.push_back(v);
        for (int v = 300; v < 65536; v += 1009) q.push_back(v);
        q.push_back(9999);
        q.push_back(10000);
        q.push_back(65535);
        foreach (q[i]) begin
            go(3, q[i]);
            wait_done(3, lat);
            eb = m_bcd(q[i], 5);
            eh = m_hex(q[i], 5, 1'b1);
            tot++; if (lat != 17) begin bad++; $display("FAIL lat_d v=%0d got=%0d want=17", q[i], lat); end
            tot++; if (bcd_d !== eb[19:0]) begin bad++; $display("FAIL bcd_d v=%0d got=%h want=%h", q[i], bcd_d, eb[19:0]); end
            tot++; if (hex_d !== eh[34:0]) begin bad++; $display("FAIL hex_d v=%0d got=%h want=%h", q[i], hex_d, eh[34:0]); end
            tot++; if (ovf_d !== 1'b0) begin bad++; $display("FAIL ovf_d v=%0d got=%h want=0", q[i], ovf_d); end
        end
    endtask

    initial begin
        tot = 0;
        bad = 0;
        rst_n = 1'b0;
        s_a = 1'b0; s_b = 1'b0; s_c = 1'b0; s_d = 1'b0;
        v_a = '0; v_b = '0; v_c = '0; v_d = '0;
        test_reset();
        test_convert_255();
        test_values();
        test_overflow();
        test_back_to_back();
        test_reset_mid_shift();
        test_sweep_16();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
